// File: rtl/quad_lo_pkg.sv
// quad_lo_pkg: shared quadrant encoding for the quadrature LO bank.
// Quadrants use a 2-bit Gray sequence so only one bit toggles per step.
package quad_lo_pkg;

  typedef logic [1:0] quad_t;

  localparam quad_t Q0 = 2'b00;
  localparam quad_t Q1 = 2'b01;
  localparam quad_t Q2 = 2'b11;
  localparam quad_t Q3 = 2'b10;

  // Successor quadrant in the Q0->Q1->Q2->Q3->Q0 rotation.
  function automatic quad_t quad_next(input quad_t q);
    quad_t r;
    case (q)
      Q0:      r = Q1;
      Q1:      r = Q2;
      Q2:      r = Q3;
      default: r = Q0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_lo_chan.sv
// quad_lo_chan: one quadrature LO channel.
// Holds active and staged {en, div}, a pending flag, the quarter counter and
// the quadrant. Staged values are applied only at the period boundary, on
// sync, or immediately when the channel is idle, so a running period is never
// truncated by a config change.
// Ports:
//   clk, rstb       clock, async active-low reset
//   wr              accepted write for this channel (only asserted when !pend)
//   wr_en, wr_div   staged values to load
//   sync            global realign pulse
//   pend            staged config waiting to be applied
//   sin, cos        registered quadrature outputs
//   pstrobe         (QUAD_LO_PSTROBE_EN only) registered period-start pulse
module quad_lo_chan
  import quad_lo_pkg::*;
#(
  parameter int unsigned DIV_W = 12
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             wr,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             sync,
  output logic             pend,
  output logic             sin,
  output logic             cos
`ifdef QUAD_LO_PSTROBE_EN
  ,
  output logic             pstrobe
`endif
);

  logic             en_q,     en_nx;
  logic [DIV_W-1:0] div_q,    div_nx;
  logic             stg_en_q, stg_en_nx;
  logic [DIV_W-1:0] stg_div_q, stg_div_nx;
  logic             pend_q,   pend_nx;
  logic [DIV_W-1:0] cnt_q,    cnt_nx;
  quad_t            qd_q,     qd_nx;
  logic             sin_q,    sin_nx;
  logic             cos_q,    cos_nx;
  logic             boundary;
  logic             apply;

  // Next-state: apply staged config, realign, or advance the phase.
  always_comb begin
    en_nx      = en_q;
    div_nx     = div_q;
    stg_en_nx  = stg_en_q;
    stg_div_nx = stg_div_q;
    pend_nx    = pend_q;
    cnt_nx     = cnt_q;
    qd_nx      = qd_q;

    boundary = en_q && (qd_q == Q3) && (cnt_q == div_q);
    apply    = pend_q && (!en_q || boundary || sync);

    if (apply) begin
      en_nx   = stg_en_q;
      div_nx  = stg_div_q;
      pend_nx = 1'b0;
      cnt_nx  = '0;
      qd_nx   = Q0;
    end else if (en_q) begin
      if (sync) begin
        cnt_nx = '0;
        qd_nx  = Q0;
      end else if (cnt_q == div_q) begin
        cnt_nx = '0;
        qd_nx  = quad_next(qd_q);
      end else begin
        cnt_nx = cnt_q + DIV_W'(1);
      end
    end

    // A write is only accepted with pend_q=0, so it never races an apply.
    if (wr) begin
      stg_en_nx  = wr_en;
      stg_div_nx = wr_div;
      pend_nx    = 1'b1;
    end

    // Outputs registered from next state so they align with the quadrant.
    sin_nx = en_nx && ((qd_nx == Q0) || (qd_nx == Q1));
    cos_nx = en_nx && ((qd_nx == Q3) || (qd_nx == Q0));
  end

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      en_q      <= 1'b0;
      div_q     <= '0;
      stg_en_q  <= 1'b0;
      stg_div_q <= '0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      qd_q      <= Q0;
      sin_q     <= 1'b0;
      cos_q     <= 1'b0;
    end else begin
      en_q      <= en_nx;
      div_q     <= div_nx;
      stg_en_q  <= stg_en_nx;
      stg_div_q <= stg_div_nx;
      pend_q    <= pend_nx;
      cnt_q     <= cnt_nx;
      qd_q      <= qd_nx;
      sin_q     <= sin_nx;
      cos_q     <= cos_nx;
    end
  end

  assign pend = pend_q;
  assign sin  = sin_q;
  assign cos  = cos_q;

`ifdef QUAD_LO_PSTROBE_EN
  logic pstrobe_q;

  // Period-start pulse, coincident with the rising edge of sin.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) pstrobe_q <= 1'b0;
    else       pstrobe_q <= en_nx && (qd_nx == Q0) && (cnt_nx == '0);
  end

  assign pstrobe = pstrobe_q;
`endif

endmodule

// File: rtl/quad_lo_bank.sv
// quad_lo_bank: bank of NCH independent quadrature square-wave LOs.
// Decodes config writes to per-channel staging, fans out sync, and exposes
// the combinational cfg_ready handshake (low while the target channel still
// has a staged config waiting for its period boundary).
// Optional feature: define QUAD_LO_PSTROBE_EN to add the pstrobe output.
// Ports:
//   clk, rstb          clock, async active-low reset
//   cfg_valid/ready    write handshake
//   cfg_ch             target channel; values >= NCH are ready and discarded
//   cfg_en, cfg_div    enable and quarter-period-minus-one to stage
//   sync               one-cycle global phase realign
//   sin_out, cos_out   per-channel quadrature outputs (cos leads sin)
//   pstrobe            (QUAD_LO_PSTROBE_EN only) per-channel period start
module quad_lo_bank
  import quad_lo_pkg::*;
#(
  parameter  int unsigned NCH   = 4,
  parameter  int unsigned DIV_W = 12,
  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             sync,
  output logic [NCH-1:0]   sin_out,
  output logic [NCH-1:0]   cos_out
`ifdef QUAD_LO_PSTROBE_EN
  ,
  output logic [NCH-1:0]   pstrobe
`endif
);

  localparam int unsigned NSLOT = 1 << CH_W;

  logic [NCH-1:0]   pend;
  logic [NSLOT-1:0] pend_ext;

  // Unused channel slots read as not pending, so out-of-range is ready.
  always_comb begin
    pend_ext          = '0;
    pend_ext[NCH-1:0] = pend;
  end

  assign cfg_ready = ~pend_ext[cfg_ch];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic wr_sel;

    assign wr_sel = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

    quad_lo_chan #(
      .DIV_W (DIV_W)
    ) u_chan (
      .clk     (clk),
      .rstb    (rstb),
      .wr      (wr_sel),
      .wr_en   (cfg_en),
      .wr_div  (cfg_div),
      .sync    (sync),
      .pend    (pend[g]),
      .sin     (sin_out[g]),
      .cos     (cos_out[g])
`ifdef QUAD_LO_PSTROBE_EN
      ,
      .pstrobe (pstrobe[g])
`endif
    );
  end

endmodule

// File: tb/tb_quad_lo_bank.sv
// tb_quad_lo_bank: directed bench with a position-based reference model.
// Each cycle the model's expected outputs are pushed to a scoreboard queue
// when stimulus is driven and popped for comparison after the clock edge.
module tb_quad_lo_bank;

  localparam int NCH   = 4;
  localparam int DIV_W = 12;

  logic             clk = 1'b0;
  logic             rstb = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch = '0;
  logic             cfg_en = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             sync = 1'b0;
  logic [NCH-1:0]   sin_out;
  logic [NCH-1:0]   cos_out;
`ifdef QUAD_LO_PSTROBE_EN
  logic [NCH-1:0]   pstrobe;
`endif

  quad_lo_bank #(.NCH(NCH), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_en    (cfg_en),
    .cfg_div   (cfg_div),
    .sync      (sync),
    .sin_out   (sin_out),
    .cos_out   (cos_out)
`ifdef QUAD_LO_PSTROBE_EN
    ,
    .pstrobe   (pstrobe)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [NCH-1:0] s;
    logic [NCH-1:0] c;
    logic [NCH-1:0] p;
  } exp_t;

  exp_t sb[$];

  // Model: phase position within the period rather than counter/quadrant.
  bit m_en[NCH];
  bit m_pend[NCH];
  bit m_sen[NCH];
  int m_div[NCH];
  int m_pos[NCH];
  int m_sdiv[NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_pend[c] = 0; m_sen[c] = 0;
      m_div[c] = 0; m_pos[c] = 0; m_sdiv[c] = 0;
    end
  endtask

  task automatic model_step(input bit wr, input int ch, input bit en, input int dv, input bit sy);
    for (int c = 0; c < NCH; c++) begin
      int per;
      bit bnd;
      per = 4 * (m_div[c] + 1);
      bnd = m_en[c] && (m_pos[c] == per - 1);
      if (m_pend[c] && (!m_en[c] || bnd || sy)) begin
        m_en[c] = m_sen[c]; m_div[c] = m_sdiv[c]; m_pend[c] = 0; m_pos[c] = 0;
      end else if (m_en[c]) begin
        m_pos[c] = sy ? 0 : (m_pos[c] + 1) % per;
      end
      if (wr && ch == c) begin
        m_pend[c] = 1; m_sen[c] = en; m_sdiv[c] = dv;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      int q;
      q = m_div[c] + 1;
      e.s[c] = m_en[c] && (m_pos[c] < 2 * q);
      e.c[c] = m_en[c] && ((m_pos[c] < q) || (m_pos[c] >= 3 * q));
      e.p[c] = m_en[c] && (m_pos[c] == 0);
    end
    return e;
  endfunction

  // One clock: drive, check ready, push expectation, clock, pop and compare.
  task automatic cycle(input bit v, input int ch, input bit en, input int dv, input bit sy,
                       input string tag);
    bit   exp_rdy;
    exp_t e;
    cfg_valid = v; cfg_ch = 2'(ch); cfg_en = en; cfg_div = DIV_W'(dv); sync = sy;
    #1;
    exp_rdy = (ch >= NCH) || !m_pend[ch];
    check({tag, "/ready"}, 32'(cfg_ready), 32'(exp_rdy));
    model_step(v && exp_rdy, ch, en, dv, sy);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    cfg_valid = 1'b0; sync = 1'b0;
    e = sb.pop_front();
    check({tag, "/sin"}, 32'(sin_out), 32'(e.s));
    check({tag, "/cos"}, 32'(cos_out), 32'(e.c));
`ifdef QUAD_LO_PSTROBE_EN
    check({tag, "/pstrobe"}, 32'(pstrobe), 32'(e.p));
`endif
  endtask

  task automatic idle(input int n, input int probe);
    repeat (n) cycle(1'b0, probe, 1'b0, 0, 1'b0, "run");
  endtask

  initial begin
    logic [15:0] hs;
    logic [15:0] hc;
    logic [7:0]  h8s;
    logic [7:0]  h8c;

    // Reset state.
    model_reset();
    #2;
    check("rst_sin", 32'(sin_out), 32'h0);
    check("rst_cos", 32'(cos_out), 32'h0);
    for (int c = 0; c < NCH; c++) begin
      cfg_ch = 2'(c);
      #1;
      check("rst_ready", 32'(cfg_ready), 32'h1);
    end
    @(posedge clk);
    #1;
    check("rst_hold", 32'({sin_out, cos_out}), 32'h0);
    #1 rstb = 1'b1;

    // ch0 div=1: 8-cycle period, first 1 on the edge after acceptance.
    cycle(1'b1, 0, 1'b1, 1, 1'b0, "wr0");
    check("wr0_pend_ready", 32'(cfg_ready), 32'h0);
    hs = '0; hc = '0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 0, 1'b0, 0, 1'b0, "ch0run");
      hs = {hs[14:0], sin_out[0]};
      hc = {hc[14:0], cos_out[0]};
    end
    check("ch0_sin_pat", 32'(hs), 32'h0000_F0F0);
    check("ch0_cos_pat", 32'(hc), 32'h0000_C3C3);

    // ch1 div=3, then div=0 written mid-Q1: held pending until boundary.
    cycle(1'b1, 1, 1'b1, 3, 1'b0, "wr1");
    idle(6, 1);
    cycle(1'b1, 1, 1'b1, 0, 1'b0, "wr1b");
    cfg_ch = 2'd1;
    #1;
    check("ch1_ready_low", 32'(cfg_ready), 32'h0);
    for (int k = 0; k < 40 && m_pend[1]; k++) cycle(1'b0, 1, 1'b0, 0, 1'b0, "ch1wait");
    check("ch1_applied_ready", 32'(cfg_ready), 32'h1);
    h8s = {7'b0, sin_out[1]};
    h8c = {7'b0, cos_out[1]};
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1, 1'b0, 0, 1'b0, "ch1fast");
      h8s = {h8s[6:0], sin_out[1]};
      h8c = {h8c[6:0], cos_out[1]};
    end
    check("ch1_div0_sin", 32'(h8s), 32'hCC);
    check("ch1_div0_cos", 32'(h8c), 32'h99);

    // ch0 div=2, ch2 div=5, then sync aligns both to Q0.
    cycle(1'b1, 0, 1'b1, 2, 1'b0, "wr0d2");
    cycle(1'b1, 2, 1'b1, 5, 1'b0, "wr2");
    idle(17, 0);
    cycle(1'b0, 0, 1'b0, 0, 1'b1, "sync");
    check("sync_align", 32'({sin_out[2], cos_out[2], sin_out[0], cos_out[0]}), 32'hF);
    idle(10, 2);

    // ch3 write coincident with sync keeps old div through the sync.
    cycle(1'b1, 3, 1'b1, 2, 1'b0, "wr3");
    idle(5, 3);
    cycle(1'b1, 3, 1'b1, 4, 1'b1, "wr3sync");
    cfg_ch = 2'd3;
    #1;
    check("ch3_still_pend", 32'(cfg_ready), 32'h0);
    idle(30, 3);

    // Disable ch2: outputs drop only after its period completes.
    cycle(1'b1, 2, 1'b0, 0, 1'b0, "dis2");
    idle(30, 2);

    // Run ch0 to mid-Q2 and assert reset between edges.
    for (int k = 0; k < 20 && !(m_en[0] && m_pos[0] == 7); k++)
      cycle(1'b0, 0, 1'b0, 0, 1'b0, "toq2");
    check("pre_rst_active", 32'((sin_out | cos_out) != '0), 32'h1);
    #2 rstb = 1'b0;
    #1;
    check("async_rst_sin", 32'(sin_out), 32'h0);
    check("async_rst_cos", 32'(cos_out), 32'h0);
    check("async_rst_ready", 32'(cfg_ready), 32'h1);
    model_reset();
    @(posedge clk);
    #2 rstb = 1'b1;

    // First write after release, div=0 on ch0.
    cycle(1'b1, 0, 1'b1, 0, 1'b0, "post_rst_wr");
    idle(8, 0);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_lo_bank.md
QUAD_LO_BANK -- requirements
Module: quad_lo_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent LO channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 12, width of the quarter-period divide word.
REQ-003 SHALL have port clk  input  1  master clock; all state updates on its rising edge.
REQ-004 SHALL have port rstb  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_valid  input  1  config write request.
REQ-006 SHALL have port cfg_ready  output  1  config write can be accepted.
REQ-007 SHALL have port cfg_ch  input  max(1,clog2(NCH))  target channel of the write.
REQ-008 SHALL have port cfg_en  input  1  channel enable value to write.
REQ-009 SHALL have port cfg_div  input  DIV_W  quarter-period minus 1, in clk cycles.
REQ-010 SHALL have port sync  input  1  one-cycle global phase-realign pulse.
REQ-011 SHALL have port sin_out  output  NCH  in-phase square wave per channel, registered.
REQ-012 SHALL have port cos_out  output  NCH  quadrature square wave per channel (leads sin by 90 deg), registered.

Function
REQ-013 Each channel SHALL hold an active {en, div}, a staged {en, div}, a pending flag, a quarter counter cnt (DIV_W bits) and a quadrant qd (Q0,Q1,Q2,Q3, Gray-coded 00,01,11,10).
REQ-014 A write SHALL be accepted on a clk edge with cfg_valid=1 and cfg_ready=1; it loads the staged {en, div} of channel cfg_ch and sets that channel's pending flag.
REQ-015 cfg_ready SHALL be a combinational function: !pending[cfg_ch]. A cfg_ch value >= NCH SHALL make cfg_ready=1, and a write accepted with that value SHALL be discarded.
REQ-016 An enabled channel SHALL increment cnt each cycle; at cnt==div, cnt SHALL clear and qd SHALL advance Q0->Q1->Q2->Q3->Q0. The period is 4*(div+1) cycles.
REQ-017 The period boundary SHALL be the cycle with qd=Q3 and cnt=div. At that edge, if pending, the staged values SHALL become active, pending SHALL clear, and the channel SHALL restart at Q0/cnt=0. If the staged en=0, the channel SHALL go idle instead.
REQ-018 An idle (disabled) channel with pending set SHALL apply the staged values on the edge after acceptance. If enabled, it SHALL start at Q0/cnt=0.
REQ-019 sin_out[c] SHALL be registered and equal 1 iff the channel is enabled and qd in {Q0,Q1}. cos_out[c] SHALL be registered and equal 1 iff the channel is enabled and qd in {Q3,Q0}. Both outputs SHALL be 1 on the first enabled cycle.
REQ-020 A disabled channel SHALL drive sin_out=cos_out=0, hold cnt=0 and hold qd=Q0.
REQ-021 A sync pulse SHALL, on the next edge, force every enabled channel to Q0/cnt=0 and apply the pending config of every channel as if it were at the period boundary.
REQ-022 For a sync coincident with a write accept on the same channel, the sync SHALL act on the prior state. The new write SHALL stay pending until the following boundary or sync.
REQ-023 A write of div=0 SHALL be legal and give a period of 4 cycles (sin: 1100, cos: 1001).
REQ-024 Outputs SHALL be glitch-free: a change of divide or enable SHALL never truncate a running period except through sync.

Reset
REQ-025 While rstb=0, all channels SHALL be disabled with div=0, pending=0, cnt=0 and qd=Q0, and sin_out=cos_out=0. cfg_ready SHALL read 1 for every cfg_ch.
REQ-026 Reset assertion mid-period SHALL take effect asynchronously. The first write is acceptable on the first edge after release.

Configuration
REQ-027 With macro QUAD_LO_PSTROBE_EN defined, the block SHALL add output port pstrobe (output, NCH bits): a registered one-cycle pulse asserted in the cycle a channel is at Q0/cnt=0 while enabled.
REQ-028 Without QUAD_LO_PSTROBE_EN, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package quad_lo_pkg SHALL hold the quadrant typedef (2-bit Gray encoding) and the constants Q0..Q3.
REQ-030 The per-channel counter, quadrant, staging and output logic SHALL be sub-module quad_lo_chan, instantiated NCH times by a generate loop. Top-level write decode and sync fan-out SHALL be kept in quad_lo_bank.

Verification
REQ-031 Reset release, write ch0 en=1 div=1 -> sin_out[0] pattern 11110000 repeating and cos_out[0] pattern 11000011, first 1 on the edge after acceptance.
REQ-032 ch1 running div=3, write div=0 mid-Q1 -> cfg_ready=0 for ch1 until the Q3/cnt=3 edge, then a 4-cycle period starts with no short pulse.
REQ-033 ch0 div=2, ch2 div=5, sync pulse -> both channels at Q0 next cycle, with sin=cos=1 and rising edges aligned.
REQ-034 Write to ch3 coincident with sync -> ch3 keeps its old div through the sync, and the new div takes effect at the next boundary.
REQ-035 Disable via write en=0 -> outputs go to 0 only after the period completes. rstb asserted mid-Q2 -> all outputs 0 immediately.
REQ-036 With QUAD_LO_PSTROBE_EN, div=1 -> pstrobe[0] pulses every 8 cycles, coincident with the rising edge of sin_out[0].
